// File: rtl/code_entry_buffer.sv
// Keypad digit collector and code comparator feeding the lock control FSM.
// Optional macro PROGRAM_EN adds prog/prog_done and a reprogrammable stored code.
module code_entry_buffer #(
    parameter int                     CODE_LEN     = 4,
    parameter logic [CODE_LEN*4-1:0]  DEFAULT_CODE = 16'h1234
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ready_for_input,
    input  logic                             digit_valid,
    input  logic [3:0]                       digit,
    input  logic                             backspace,
    input  logic                             clear,
    input  logic                             submit,
    output logic                             full,
    output logic                             match,
    output logic [$clog2(CODE_LEN+1)-1:0]    count,
    output logic                             digit_err
`ifdef PROGRAM_EN
    ,
    input  logic                             prog,
    output logic                             prog_done
`endif
);

    localparam int CW = $clog2(CODE_LEN+1);
    localparam int EW = CODE_LEN*4;
    localparam logic [CW-1:0] LAST_IDX = CW'(CODE_LEN-1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [EW-1:0]   entry_reg, entry_next;
    logic            digit_err_reg;
    logic [EW-1:0]   code_reg;

    // One action per edge, resolved by priority clear > submit > backspace > digit.
    logic act_clear, act_submit, act_back, act_digit, store, bad_digit, flush;

    always_comb begin
        act_clear  = clear;
        act_submit = !clear && submit;
        act_back   = !clear && !submit && backspace;
        act_digit  = !clear && !submit && !backspace &&
                     digit_valid && ready_for_input && (state_reg != ST_FULL);
        store      = act_digit && (digit <= 4'd9);
        bad_digit  = act_digit && (digit > 4'd9);
        flush      = act_clear || act_submit;
    end

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_EMPTY: begin
                if (store)
                    state_next = (CODE_LEN == 1) ? ST_FULL : ST_ENTRY;
            end
            ST_ENTRY: begin
                if (act_back)
                    state_next = (count_reg == ONE) ? ST_EMPTY : ST_ENTRY;
                else if (store)
                    state_next = (count_reg == LAST_IDX) ? ST_FULL : ST_ENTRY;
            end
            ST_FULL: begin
                if (act_back)
                    state_next = (CODE_LEN == 1) ? ST_EMPTY : ST_ENTRY;
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush)
            state_next = ST_EMPTY;
    end

    always_comb begin
        count_next = count_reg;
        if (flush)
            count_next = '0;
        else if (act_back && (count_reg != '0))
            count_next = count_reg - ONE;
        else if (store)
            count_next = count_reg + ONE;
    end

    // Slot 0 (first digit typed) lives in the MSBs so the entry compares directly with the code.
    generate
        for (genvar gi = 0; gi < CODE_LEN; gi++) begin : g_slot
            localparam int            SLOT_LSB = (CODE_LEN-1-gi)*4;
            localparam logic [CW-1:0] SLOT_IDX = CW'(gi);
            localparam logic [CW-1:0] SLOT_TOP = CW'(gi+1);

            assign entry_next[SLOT_LSB +: 4] =
                flush                                  ? 4'd0  :
                (store    && count_reg == SLOT_IDX)    ? digit :
                (act_back && count_reg == SLOT_TOP)    ? 4'd0  :
                                                         entry_reg[SLOT_LSB +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_EMPTY;
            count_reg     <= '0;
            entry_reg     <= '0;
            digit_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            entry_reg     <= entry_next;
            digit_err_reg <= bad_digit;
        end
    end

`ifdef PROGRAM_EN
    logic prog_done_reg;
    logic do_prog;

    // Only a full entry can become the new code; match keeps showing the old code until the edge.
    assign do_prog = act_submit && prog && (state_reg == ST_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            code_reg      <= DEFAULT_CODE;
            prog_done_reg <= 1'b0;
        end else begin
            if (do_prog)
                code_reg <= entry_reg;
            prog_done_reg <= do_prog;
        end
    end

    assign prog_done = prog_done_reg;
`else
    assign code_reg = DEFAULT_CODE;
`endif

    assign full      = (state_reg == ST_FULL);
    assign match     = full && (entry_reg == code_reg);
    assign count     = count_reg;
    assign digit_err = digit_err_reg;

endmodule

// File: tb/tb_code_entry_buffer.sv
// Randomized self-checking bench for code_entry_buffer against a queue-based model.
// Exercises prog/prog_done too when PROGRAM_EN is defined.
module tb_code_entry_buffer;

    localparam int L  = 4;
    localparam int CW = $clog2(L+1);
`ifdef PROGRAM_EN
    localparam bit PROG_EN = 1'b1;
`else
    localparam bit PROG_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ready_for_input = 1'b0;
    logic          digit_valid = 1'b0;
    logic [3:0]    digit = 4'd0;
    logic          backspace = 1'b0;
    logic          clear = 1'b0;
    logic          submit = 1'b0;
    logic          prog = 1'b0;
    logic          full, match, digit_err;
    logic [CW-1:0] count;
    logic          prog_done;

    code_entry_buffer #(.CODE_LEN(L), .DEFAULT_CODE(16'h1234)) dut (
        .clk(clk), .rst(rst), .ready_for_input(ready_for_input),
        .digit_valid(digit_valid), .digit(digit), .backspace(backspace),
        .clear(clear), .submit(submit), .full(full), .match(match),
        .count(count), .digit_err(digit_err)
`ifdef PROGRAM_EN
        , .prog(prog), .prog_done(prog_done)
`endif
    );

`ifndef PROGRAM_EN
    assign prog_done = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: the entry is just a list of typed digits.
    int q[$];
    int code_m[L];
    bit err_m, pd_m;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic load_default();
        logic [15:0] def;
        def = 16'h1234;
        for (int i = 0; i < L; i++) code_m[i] = int'((def >> ((L-1-i)*4)) & 16'hF);
    endtask

    function automatic bit model_match();
        if (q.size() != L) return 1'b0;
        for (int i = 0; i < L; i++) if (q[i] != code_m[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update(input bit r, rdy, dv, input int d, input bit bs, cl, sb, pr);
        err_m = 1'b0;
        pd_m  = 1'b0;
        if (r) begin
            q.delete();
            load_default();
        end else if (cl) begin
            q.delete();
        end else if (sb) begin
            if (PROG_EN && pr && q.size() == L) begin
                for (int i = 0; i < L; i++) code_m[i] = q[i];
                pd_m = 1'b1;
            end
            q.delete();
        end else if (bs) begin
            if (q.size() > 0) void'(q.pop_back());
        end else if (dv && rdy && q.size() < L) begin
            if (d <= 9) q.push_back(d);
            else err_m = 1'b1;
        end
    endtask

    task automatic step(input bit r, rdy, dv, input int d, input bit bs, cl, sb, pr);
        rst = r; ready_for_input = rdy; digit_valid = dv; digit = 4'(d);
        backspace = bs; clear = cl; submit = sb; prog = pr;
        @(posedge clk);
        #1;
        cyc++;
        model_update(r, rdy, dv, d, bs, cl, sb, pr);
        $display("cyc=%0d rst=%b rdy=%b dv=%b d=%0d bs=%b cl=%b sb=%b pr=%b -> count=%0d full=%b match=%b err=%b pd=%b",
                 cyc, r, rdy, dv, d, bs, cl, sb, pr, count, full, match, digit_err, prog_done);
        check_value("count",     32'(count),     32'(q.size()));
        check_value("full",      32'(full),      32'(q.size() == L));
        check_value("match",     32'(match),     32'(model_match()));
        check_value("digit_err", 32'(digit_err), 32'(err_m));
        if (PROG_EN) check_value("prog_done", 32'(prog_done), 32'(pd_m));
    endtask

    task automatic idle();
        step(0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic key(input int d);
        step(0, 1, 1, d, 0, 0, 0, 0);
    endtask

    task automatic key4(input int a, b, c, e, input bit pr_last);
        key(a); key(b); key(c); key(e);
        if (pr_last) step(0, 1, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        int d;
        bit r, rdy, dv, bs, cl, sb, pr;
        load_default();

        // Reset state
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check_value("rst_count", 32'(count), 32'd0);

        // Correct code, then submit empties
        key4(1, 2, 3, 4, 0);
        check_value("t1_match", 32'(match), 32'd1);
        check_value("t1_count", 32'(count), 32'd4);
        step(0, 1, 0, 0, 0, 0, 1, 0);
        check_value("t1_submit_full", 32'(full), 32'd0);

        // Wrong code, clear
        key4(1, 2, 3, 5, 0);
        check_value("t2_match", 32'(match), 32'd0);
        check_value("t2_full", 32'(full), 32'd1);
        step(0, 1, 0, 0, 0, 1, 0, 0);

        // Invalid digit and ignored digit
        key(1);
        key(10);
        check_value("t3_err", 32'(digit_err), 32'd1);
        step(0, 0, 1, 2, 0, 0, 0, 0);
        check_value("t3_err_gone", 32'(digit_err), 32'd0);
        step(0, 1, 0, 0, 0, 1, 0, 0);

        // Backspace editing, backspace at 0, digit while full
        key(1); key(2); key(9);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        key(3); key(4);
        check_value("t4_match", 32'(match), 32'd1);
        key(7);
        check_value("t4_full_ignore", 32'(match), 32'd1);
        step(0, 1, 0, 0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 1, 0, 0, 0);
        check_value("t4_bs_empty", 32'(count), 32'd0);

        // Simultaneous clear/submit/digit, reset mid-entry
        key(5);
        step(0, 1, 1, 6, 0, 1, 1, 0);
        key(1); key(2);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        check_value("t5_rst_count", 32'(count), 32'd0);

        if (PROG_EN) begin
            key4(9, 8, 7, 6, 1);
            key4(1, 2, 3, 4, 0);
            check_value("t6_old_code", 32'(match), 32'd0);
            step(0, 1, 0, 0, 0, 1, 0, 0);
            key4(9, 8, 7, 6, 0);
            check_value("t6_new_code", 32'(match), 32'd1);
            step(1, 1, 0, 0, 0, 0, 0, 0);
            key4(1, 2, 3, 4, 0);
            check_value("t6_default_back", 32'(match), 32'd1);
            step(0, 1, 0, 0, 0, 1, 0, 0);
        end

        // Randomized traffic, digits biased toward the current code so matches occur
        for (int n = 0; n < 1500; n++) begin
            r   = ($urandom_range(0, 199) == 0);
            rdy = ($urandom_range(0, 9) != 0);
            dv  = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 9) < 6 && q.size() < L) d = code_m[q.size()];
            else d = int'($urandom_range(0, 11));
            bs  = ($urandom_range(0, 11) == 0);
            cl  = ($urandom_range(0, 29) == 0);
            sb  = ($urandom_range(0, 9) == 0);
            pr  = ($urandom_range(0, 3) == 0);
            step(r, rdy, dv, d, bs, cl, sb, pr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
